// File: rtl/decode_stage.sv
// Instruction decode stage: 32-entry register file with write-through bypass,
// RV32I/RV64I opcode decoding, a load-use interlock, and one output register
// slice with a valid/ready handshake on both sides.
// XLEN must be 32 or 64.
module decode_stage #(
    parameter int unsigned XLEN = 64,
    parameter bit          RV64 = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic            i_wb_wr_reg_en,
    input  logic [4:0]      i_wb_wr_reg_addr,
    input  logic [XLEN-1:0] i_wb_wr_reg_data,
    input  logic            i_ex_load_valid,
    input  logic [4:0]      i_ex_load_rd,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_rs1_data,
    output logic [XLEN-1:0] o_id_rs2_data,
    output logic [XLEN-1:0] o_id_imm,
    output logic [4:0]      o_id_rd_addr,
    output logic            o_id_rd_wen,
    output logic [2:0]      o_id_funct3,
    output logic            o_id_funct7b5,
    output logic            o_id_word,
    output logic [3:0]      o_id_opclass,
    output logic            o_id_illegal
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpReg32  = 7'b0111011;

    localparam logic [3:0] ClsLui     = 4'd0;
    localparam logic [3:0] ClsAuipc   = 4'd1;
    localparam logic [3:0] ClsJal     = 4'd2;
    localparam logic [3:0] ClsJalr    = 4'd3;
    localparam logic [3:0] ClsBranch  = 4'd4;
    localparam logic [3:0] ClsLoad    = 4'd5;
    localparam logic [3:0] ClsStore   = 4'd6;
    localparam logic [3:0] ClsOpImm   = 4'd7;
    localparam logic [3:0] ClsOp      = 4'd8;
    localparam logic [3:0] ClsOpImm32 = 4'd9;
    localparam logic [3:0] ClsOp32    = 4'd10;
    localparam logic [3:0] ClsIllegal = 4'd15;

    logic [XLEN-1:0] rf_q [32];

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            rd_wen_q, rd_wen_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            funct7b5_q, funct7b5_d;
    logic            word_q, word_d;
    logic [3:0]      opclass_q, opclass_d;
    logic            illegal_q, illegal_d;
    // Source addresses of the held instruction (0 when unused) for late WB capture.
    logic [4:0]      rs1_addr_q, rs1_addr_d;
    logic [4:0]      rs2_addr_q, rs2_addr_d;

    logic [6:0]      opcode;
    logic [4:0]      rs1_a, rs2_a, rd_a;
    logic [3:0]      cls;
    logic            rs1_used, rs2_used, writes_rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] rs1_rd, rs2_rd;
    logic            hazard, accept, hold;

    assign opcode = i_if_instr[6:0];
    assign rd_a   = i_if_instr[11:7];
    assign rs1_a  = i_if_instr[19:15];
    assign rs2_a  = i_if_instr[24:20];

    // Opcode to operation class; the 32-bit word ops exist only on RV64.
    always_comb begin
        cls = ClsIllegal;
        case (opcode)
            OpLui:    cls = ClsLui;
            OpAuipc:  cls = ClsAuipc;
            OpJal:    cls = ClsJal;
            OpJalr:   cls = ClsJalr;
            OpBranch: cls = ClsBranch;
            OpLoad:   cls = ClsLoad;
            OpStore:  cls = ClsStore;
            OpImm:    cls = ClsOpImm;
            OpReg:    cls = ClsOp;
            OpImm32:  cls = RV64 ? ClsOpImm32 : ClsIllegal;
            OpReg32:  cls = RV64 ? ClsOp32 : ClsIllegal;
            default:  cls = ClsIllegal;
        endcase
    end

    // Per-class operand usage, rd write and immediate format.
    always_comb begin
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        writes_rd = 1'b0;
        imm32     = '0;
        case (cls)
            ClsLui, ClsAuipc: begin
                writes_rd = 1'b1;
                imm32     = {i_if_instr[31:12], 12'b0};
            end
            ClsJal: begin
                writes_rd = 1'b1;
                imm32     = {{12{i_if_instr[31]}}, i_if_instr[19:12], i_if_instr[20],
                             i_if_instr[30:21], 1'b0};
            end
            ClsJalr, ClsLoad, ClsOpImm, ClsOpImm32: begin
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                imm32     = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
            end
            ClsBranch: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{20{i_if_instr[31]}}, i_if_instr[7], i_if_instr[30:25],
                            i_if_instr[11:8], 1'b0};
            end
            ClsStore: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{20{i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
            end
            ClsOp, ClsOp32: begin
                writes_rd = 1'b1;
                rs1_used  = 1'b1;
                rs2_used  = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file reads with write-through bypass from the WB port.
    always_comb begin
        if (rs1_a == 5'd0) begin
            rs1_rd = '0;
        end else if (i_wb_wr_reg_en && (i_wb_wr_reg_addr == rs1_a)) begin
            rs1_rd = i_wb_wr_reg_data;
        end else begin
            rs1_rd = rf_q[rs1_a];
        end
        if (rs2_a == 5'd0) begin
            rs2_rd = '0;
        end else if (i_wb_wr_reg_en && (i_wb_wr_reg_addr == rs2_a)) begin
            rs2_rd = i_wb_wr_reg_data;
        end else begin
            rs2_rd = rf_q[rs2_a];
        end
    end

    // Load-use interlock and handshake.
    always_comb begin
        hazard = i_ex_load_valid && (i_ex_load_rd != 5'd0) &&
                 ((rs1_used && (rs1_a == i_ex_load_rd)) ||
                  (rs2_used && (rs2_a == i_ex_load_rd)));
        o_if_ready = !i_flush && !hazard && (!valid_q || i_ex_ready);
        accept     = i_if_valid && o_if_ready;
        hold       = valid_q && !i_ex_ready;
    end

    // Next state of the output slice: load, hold (with late WB capture) or drain.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rd_addr_d  = rd_addr_q;
        rd_wen_d   = rd_wen_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        word_d     = word_q;
        opclass_d  = opclass_q;
        illegal_d  = illegal_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        if (accept) begin
            valid_d    = 1'b1;
            pc_d       = i_if_pc;
            rs1_data_d = rs1_used ? rs1_rd : '0;
            rs2_data_d = rs2_used ? rs2_rd : '0;
            rs1_addr_d = rs1_used ? rs1_a : 5'd0;
            rs2_addr_d = rs2_used ? rs2_a : 5'd0;
            imm_d      = XLEN'($signed(imm32));
            rd_addr_d  = writes_rd ? rd_a : 5'd0;
            rd_wen_d   = writes_rd && (rd_a != 5'd0);
            funct3_d   = (cls != ClsIllegal) ? i_if_instr[14:12] : 3'd0;
            funct7b5_d = (cls != ClsIllegal) && i_if_instr[30];
            word_d     = (cls == ClsOpImm32) || (cls == ClsOp32);
            opclass_d  = cls;
            illegal_d  = (cls == ClsIllegal);
        end else begin
            if (hold) begin
                if (i_wb_wr_reg_en && (i_wb_wr_reg_addr != 5'd0)) begin
                    if (i_wb_wr_reg_addr == rs1_addr_q) rs1_data_d = i_wb_wr_reg_data;
                    if (i_wb_wr_reg_addr == rs2_addr_q) rs2_data_d = i_wb_wr_reg_data;
                end
            end else begin
                valid_d = 1'b0;
            end
            if (i_flush) valid_d = 1'b0;
        end
    end

    // Register file storage; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (i_wb_wr_reg_en && (i_wb_wr_reg_addr != 5'd0)) begin
            rf_q[i_wb_wr_reg_addr] <= i_wb_wr_reg_data;
        end
    end

    // Output slice registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rd_addr_q  <= '0;
            rd_wen_q   <= 1'b0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            word_q     <= 1'b0;
            opclass_q  <= '0;
            illegal_q  <= 1'b0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rd_addr_q  <= rd_addr_d;
            rd_wen_q   <= rd_wen_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            word_q     <= word_d;
            opclass_q  <= opclass_d;
            illegal_q  <= illegal_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
        end
    end

    assign o_id_valid    = valid_q;
    assign o_id_pc       = pc_q;
    assign o_id_rs1_data = rs1_data_q;
    assign o_id_rs2_data = rs2_data_q;
    assign o_id_imm      = imm_q;
    assign o_id_rd_addr  = rd_addr_q;
    assign o_id_rd_wen   = rd_wen_q;
    assign o_id_funct3   = funct3_q;
    assign o_id_funct7b5 = funct7b5_q;
    assign o_id_word     = word_q;
    assign o_id_opclass  = opclass_q;
    assign o_id_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a cycle-level reference model,
// plus directed scenarios for bypass, interlock, hold, flush and reset.
module tb_decode_stage;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic            flush;
    logic            ex_ready;

    logic            o_if_ready, o_id_valid, o_id_rd_wen, o_id_funct7b5, o_id_word, o_id_illegal;
    logic [XLEN-1:0] o_id_pc, o_id_rs1_data, o_id_rs2_data, o_id_imm;
    logic [4:0]      o_id_rd_addr;
    logic [2:0]      o_id_funct3;
    logic [3:0]      o_id_opclass;

    logic            r32_if_ready, r32_valid, r32_rd_wen, r32_f7b5, r32_word, r32_illegal;
    logic [XLEN-1:0] r32_pc, r32_rs1, r32_rs2, r32_imm;
    logic [4:0]      r32_rd_addr;
    logic [2:0]      r32_f3;
    logic [3:0]      r32_opclass;

    decode_stage #(.XLEN(XLEN), .RV64(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_if_valid(if_valid), .o_if_ready(o_if_ready),
        .i_if_instr(if_instr), .i_if_pc(if_pc), .i_wb_wr_reg_en(wb_en),
        .i_wb_wr_reg_addr(wb_addr), .i_wb_wr_reg_data(wb_data), .i_ex_load_valid(ld_valid),
        .i_ex_load_rd(ld_rd), .i_flush(flush), .i_ex_ready(ex_ready), .o_id_valid(o_id_valid),
        .o_id_pc(o_id_pc), .o_id_rs1_data(o_id_rs1_data), .o_id_rs2_data(o_id_rs2_data),
        .o_id_imm(o_id_imm), .o_id_rd_addr(o_id_rd_addr), .o_id_rd_wen(o_id_rd_wen),
        .o_id_funct3(o_id_funct3), .o_id_funct7b5(o_id_funct7b5), .o_id_word(o_id_word),
        .o_id_opclass(o_id_opclass), .o_id_illegal(o_id_illegal)
    );

    decode_stage #(.XLEN(XLEN), .RV64(1'b0)) dut_rv32 (
        .clk(clk), .rst_n(rst_n), .i_if_valid(if_valid), .o_if_ready(r32_if_ready),
        .i_if_instr(if_instr), .i_if_pc(if_pc), .i_wb_wr_reg_en(wb_en),
        .i_wb_wr_reg_addr(wb_addr), .i_wb_wr_reg_data(wb_data), .i_ex_load_valid(ld_valid),
        .i_ex_load_rd(ld_rd), .i_flush(flush), .i_ex_ready(ex_ready), .o_id_valid(r32_valid),
        .o_id_pc(r32_pc), .o_id_rs1_data(r32_rs1), .o_id_rs2_data(r32_rs2),
        .o_id_imm(r32_imm), .o_id_rd_addr(r32_rd_addr), .o_id_rd_wen(r32_rd_wen),
        .o_id_funct3(r32_f3), .o_id_funct7b5(r32_f7b5), .o_id_word(r32_word),
        .o_id_opclass(r32_opclass), .o_id_illegal(r32_illegal)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode, built from the ISA tables with plain integer arithmetic.
    typedef struct {
        logic [3:0]  cls;
        bit          use1;
        bit          use2;
        bit          wrd;
        logic [63:0] imm;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t   d;
        longint sgn;
        longint v;
        sgn = i[31] ? -64'sd1 : 64'sd0;
        case (i[6:0])
            7'h37:   d.cls = 4'd0;
            7'h17:   d.cls = 4'd1;
            7'h6F:   d.cls = 4'd2;
            7'h67:   d.cls = 4'd3;
            7'h63:   d.cls = 4'd4;
            7'h03:   d.cls = 4'd5;
            7'h23:   d.cls = 4'd6;
            7'h13:   d.cls = 4'd7;
            7'h33:   d.cls = 4'd8;
            7'h1B:   d.cls = 4'd9;
            7'h3B:   d.cls = 4'd10;
            default: d.cls = 4'd15;
        endcase
        d.use1 = d.cls inside {[4'd3:4'd10]};
        d.use2 = d.cls inside {4'd4, 4'd6, 4'd8, 4'd10};
        d.wrd  = d.cls inside {[4'd0:4'd3], 4'd5, [4'd7:4'd10]};
        case (d.cls)
            4'd3, 4'd5, 4'd7, 4'd9:
                v = sgn * 2048 + longint'(i[30:20]);
            4'd6:
                v = sgn * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:7]);
            4'd4:
                v = sgn * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                    + longint'(i[11:8]) * 2;
            4'd0, 4'd1:
                v = sgn * (longint'(1) << 31) + longint'(i[30:12]) * 4096;
            4'd2:
                v = sgn * (longint'(1) << 20) + longint'(i[19:12]) * 4096
                    + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
            default:
                v = 0;
        endcase
        d.imm = 64'(v);
        return d;
    endfunction

    // Model state.
    logic [63:0] rf [32];
    bit          m_valid;
    logic [63:0] m_pc, m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rd, m_rs1a, m_rs2a;
    bit          m_wen, m_f7, m_word, m_ill;
    logic [2:0]  m_f3;
    logic [3:0]  m_cls;

    function automatic logic [63:0] ref_read(input logic [4:0] a);
        if (a == 0) return 64'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return rf[a];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) rf[k] = 64'd0;
        m_valid = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0; m_rd = 0; m_rs1a = 0;
        m_rs2a = 0; m_wen = 0; m_f7 = 0; m_word = 0; m_ill = 0; m_f3 = 0; m_cls = 0;
    endtask

    task automatic check_outputs();
        check_eq("id_valid", o_id_valid, m_valid);
        if (m_valid) begin
            check_eq("id_pc", o_id_pc, m_pc);
            check_eq("id_rs1_data", o_id_rs1_data, m_rs1d);
            check_eq("id_rs2_data", o_id_rs2_data, m_rs2d);
            check_eq("id_imm", o_id_imm, m_imm);
            check_eq("id_rd_addr", o_id_rd_addr, m_rd);
            check_eq("id_rd_wen", o_id_rd_wen, m_wen);
            check_eq("id_funct3", o_id_funct3, m_f3);
            check_eq("id_funct7b5", o_id_funct7b5, m_f7);
            check_eq("id_word", o_id_word, m_word);
            check_eq("id_opclass", o_id_opclass, m_cls);
            check_eq("id_illegal", o_id_illegal, m_ill);
        end
    endtask

    // One cycle: inputs are already applied just after a falling edge.
    task automatic tick();
        dec_t d;
        bit   haz, rdy, acc;
        #2;
        d   = ref_decode(if_instr);
        haz = ld_valid && (ld_rd != 0) &&
              ((d.use1 && if_instr[19:15] == ld_rd) || (d.use2 && if_instr[24:20] == ld_rd));
        rdy = !flush && !haz && (!m_valid || ex_ready);
        check_eq("if_ready", o_if_ready, rdy);
        acc = if_valid && rdy;
        if (acc) begin
            m_valid = 1;
            m_pc    = if_pc;
            m_rs1a  = d.use1 ? if_instr[19:15] : 5'd0;
            m_rs2a  = d.use2 ? if_instr[24:20] : 5'd0;
            m_rs1d  = d.use1 ? ref_read(if_instr[19:15]) : 64'd0;
            m_rs2d  = d.use2 ? ref_read(if_instr[24:20]) : 64'd0;
            m_imm   = d.imm;
            m_rd    = d.wrd ? if_instr[11:7] : 5'd0;
            m_wen   = d.wrd && (if_instr[11:7] != 0);
            m_f3    = (d.cls != 15) ? if_instr[14:12] : 3'd0;
            m_f7    = (d.cls != 15) && if_instr[30];
            m_word  = (d.cls == 9) || (d.cls == 10);
            m_cls   = d.cls;
            m_ill   = (d.cls == 15);
        end else if (m_valid && !ex_ready && !flush) begin
            if (wb_en && wb_addr != 0) begin
                if (wb_addr == m_rs1a) m_rs1d = wb_data;
                if (wb_addr == m_rs2a) m_rs2d = wb_data;
            end
        end else begin
            m_valid = 0;
        end
        if (wb_en && wb_addr != 0) rf[wb_addr] = wb_data;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_idle();
        if_valid = 0; if_instr = 32'd0; if_pc = 64'h1000; wb_en = 0; wb_addr = 0;
        wb_data = 0; ld_valid = 0; ld_rd = 0; flush = 0; ex_ready = 1;
    endtask

    // Assert reset right after a falling edge; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", o_id_valid, 0);
        check_eq("rst_pc", o_id_pc, 0);
        check_eq("rst_rs1", o_id_rs1_data, 0);
        check_eq("rst_rs2", o_id_rs2_data, 0);
        check_eq("rst_imm", o_id_imm, 0);
        check_eq("rst_opclass", o_id_opclass, 0);
        check_eq("rst_flags", {o_id_rd_wen, o_id_illegal, o_id_word, o_id_funct7b5}, 0);
        check_eq("rst_rd_f3", {o_id_rd_addr, o_id_funct3}, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] AddiX6X5M1 = {12'hFFF, 5'd5, 3'd0, 5'd6, 7'h13};
    localparam logic [31:0] AddX8X7X7  = {7'd0, 5'd7, 5'd7, 3'd0, 5'd8, 7'h33};
    localparam logic [31:0] SwX3X4     = {7'd0, 5'd3, 5'd4, 3'd2, 5'd0, 7'h23};
    localparam logic [31:0] AddX1X2X9  = {7'd0, 5'd9, 5'd2, 3'd0, 5'd1, 7'h33};
    localparam logic [31:0] AddiwX1X2  = {12'd5, 5'd2, 3'd0, 5'd1, 7'h1B};

    logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                             7'h33, 7'h1B, 7'h3B, 7'h73, 7'h0F};

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();
        tick();

        // Register write then dependent ADDI.
        set_idle(); wb_en = 1; wb_addr = 5; wb_data = 64'h1234;
        tick();
        set_idle(); if_valid = 1; if_instr = AddiX6X5M1; if_pc = 64'h100;
        tick();
        check_eq("addi_rs1", o_id_rs1_data, 64'h1234);
        check_eq("addi_imm", o_id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("addi_opclass", o_id_opclass, 7);
        check_eq("addi_rd_wen", o_id_rd_wen, 1);

        // Same-cycle bypass.
        set_idle(); wb_en = 1; wb_addr = 7; wb_data = 64'hAA; if_valid = 1; if_instr = AddX8X7X7;
        tick();
        check_eq("bypass_rs1", o_id_rs1_data, 64'hAA);
        check_eq("bypass_rs2", o_id_rs2_data, 64'hAA);

        // Load-use stall then release.
        set_idle(); ld_valid = 1; ld_rd = 3; if_valid = 1; if_instr = SwX3X4;
        #1 check_eq("lu_ready", o_if_ready, 0);
        tick();
        check_eq("lu_bubble", o_id_valid, 0);
        ld_valid = 0;
        tick();
        check_eq("lu_accept", o_id_valid, 1);
        check_eq("lu_opclass", o_id_opclass, 6);

        // Hold under backpressure with late WB into rs2.
        set_idle(); if_valid = 1; if_instr = AddX1X2X9;
        tick();
        set_idle(); ex_ready = 0; if_valid = 1; if_instr = AddiX6X5M1;
        tick();
        wb_en = 1; wb_addr = 9; wb_data = 64'h55;
        tick();
        wb_en = 0;
        tick();
        check_eq("hold_rs2", o_id_rs2_data, 64'h55);
        check_eq("hold_opclass", o_id_opclass, 8);
        check_eq("hold_rd", o_id_rd_addr, 1);
        check_eq("hold_valid", o_id_valid, 1);

        // ADDIW on RV64 versus RV32-only decode.
        set_idle(); if_valid = 1; if_instr = AddiwX1X2;
        tick();
        check_eq("addiw_opclass", o_id_opclass, 9);
        check_eq("addiw_word", o_id_word, 1);
        check_eq("rv32_opclass", r32_opclass, 15);
        check_eq("rv32_illegal", r32_illegal, 1);
        check_eq("rv32_rd_wen", r32_rd_wen, 0);
        check_eq("rv32_imm", r32_imm, 0);

        // Flush while holding valid contents.
        set_idle(); if_valid = 1; if_instr = AddX1X2X9;
        tick();
        set_idle(); ex_ready = 0; flush = 1; if_valid = 1; if_instr = AddiX6X5M1;
        #1 check_eq("flush_ready", o_if_ready, 0);
        tick();
        check_eq("flush_valid", o_id_valid, 0);

        // Reset in the middle of a hold, then a fresh accept.
        set_idle(); if_valid = 1; if_instr = AddX8X7X7;
        tick();
        set_idle(); ex_ready = 0;
        tick();
        do_reset();
        set_idle(); if_valid = 1; if_instr = AddX8X7X7;
        tick();
        check_eq("post_rst_rs1", o_id_rs1_data, 0);
        check_eq("post_rst_valid", o_id_valid, 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if_valid = ($urandom_range(3) != 0);
            if_instr = {7'($urandom), 5'($urandom_range(7)), 5'($urandom_range(7)),
                        3'($urandom), 5'($urandom_range(7)), ops[$urandom_range(12)]};
            if_pc    = {$urandom, $urandom};
            wb_en    = $urandom_range(1) != 0;
            wb_addr  = 5'($urandom_range(7));
            wb_data  = {$urandom, $urandom};
            ld_valid = ($urandom_range(9) < 3);
            ld_rd    = 5'($urandom_range(7));
            flush    = ($urandom_range(19) == 0);
            ex_ready = ($urandom_range(9) < 7);
            if ($urandom_range(499) == 0) do_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
